// File: rtl/acc_job_scheduler_if.sv
// rtl/acc_job_scheduler_if.sv - job write and accelerator handshake bundle for acc_job_scheduler
interface acc_job_scheduler_if;
    logic       job_wr_valid;
    logic       job_wr_ready;
    logic [1:0] job_wr_kind;
    logic [3:0] job_wr_tag;
    logic       acc_ap_idle;
    logic [2:0] acc_ap_start;
    logic [2:0] acc_ap_done;
    logic       acc_sm_tvalid;
    logic       acc_sm_tready;
    logic       acc_sm_tlast;

    modport slave (
        input  job_wr_valid, job_wr_kind, job_wr_tag,
        input  acc_ap_idle, acc_ap_done, acc_sm_tvalid, acc_sm_tready, acc_sm_tlast,
        output job_wr_ready, acc_ap_start
    );

    modport master (
        output job_wr_valid, job_wr_kind, job_wr_tag,
        output acc_ap_idle, acc_ap_done, acc_sm_tvalid, acc_sm_tready, acc_sm_tlast,
        input  job_wr_ready, acc_ap_start
    );
endinterface

// File: rtl/acc_job_scheduler.sv
// rtl/acc_job_scheduler.sv - job queue and one-at-a-time sequencer for the shared accelerator
module acc_job_scheduler #(
    parameter int QDEPTH     = 4,
    parameter int TIMEOUT    = 20000,
    parameter int FIR_BEATS  = 64,
    parameter int MM_BEATS   = 16,
    parameter int SORT_BEATS = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    acc_job_scheduler_if.slave        bus,
    input  logic                      abort,
    output logic                      busy,
    output logic [$clog2(QDEPTH):0]   q_level,
    output logic                      rej_pulse,
    output logic                      done_valid,
    output logic [3:0]                done_tag,
    output logic [1:0]                done_kind,
    output logic [6:0]                done_beats,
    output logic [1:0]                done_err,
    output logic [15:0]               jobs_done
);
    localparam int            AW    = $clog2(QDEPTH);
    localparam logic [AW:0]   QFULL = (AW+1)'(QDEPTH);
    localparam logic [15:0]   TLIM  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RUN, S_DRAIN, S_REPORT} state_t;
    state_t state, state_nxt;

    logic [5:0]    q_mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, rej, beat, active, done_seen, done_wrong, tmo, mism;
    logic [1:0]    cur_kind, err_nxt;
    logic [3:0]    cur_tag;
    logic [15:0]   timer;
    logic [6:0]    beats, beats_nxt, beats_exp;
    logic [2:0]    start_q;

    // Reset forces ready low so every output reads 0 while rst_n is asserted.
    assign bus.job_wr_ready = rst_n && (count != QFULL) && !abort;
    assign push       = bus.job_wr_valid && bus.job_wr_ready && (bus.job_wr_kind != 2'd3);
    assign rej        = bus.job_wr_valid && bus.job_wr_ready && (bus.job_wr_kind == 2'd3);
    assign pop        = (state == S_IDLE) && (count != '0) && bus.acc_ap_idle;
    assign active     = (state == S_RUN) || (state == S_DRAIN);
    assign beat       = active && bus.acc_sm_tvalid && bus.acc_sm_tready;
    assign done_seen  = (state == S_RUN) && (bus.acc_ap_done != 3'b000);
    assign done_wrong = done_seen && (bus.acc_ap_done != (3'b001 << cur_kind));
    assign tmo        = active && !beat && (timer >= TLIM);

    assign bus.acc_ap_start = start_q;
    assign busy       = (state != S_IDLE);
    assign done_valid = (state == S_REPORT);
    assign q_level    = count;

    always_comb begin
        beats_nxt = beats;
        if (state == S_ISSUE)
            beats_nxt = '0;
        else if (beat && beats != 7'd127)
            beats_nxt = beats + 7'd1;
    end

    always_comb begin
        case (cur_kind)
            2'd0:    beats_exp = 7'(FIR_BEATS);
            2'd1:    beats_exp = 7'(MM_BEATS);
            default: beats_exp = 7'(SORT_BEATS);
        endcase
    end

    // Error priority: timeout over done mismatch over beat-count mismatch.
    always_comb begin
        err_nxt = 2'd0;
        if (tmo)
            err_nxt = 2'd2;
        else if (mism)
            err_nxt = 2'd3;
        else if (beats_nxt != beats_exp)
            err_nxt = 2'd1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pop) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_RUN;
            S_RUN: begin
                if (done_seen)
                    state_nxt = S_DRAIN;
                else if (tmo)
                    state_nxt = S_REPORT;
            end
            S_DRAIN: begin
                if (beat && bus.acc_sm_tlast)
                    state_nxt = S_REPORT;
                else if (tmo)
                    state_nxt = S_REPORT;
            end
            S_REPORT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            q_mem[wr_ptr] <= {bus.job_wr_kind, bus.job_wr_tag};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            start_q    <= '0;
            cur_kind   <= '0;
            cur_tag    <= '0;
            timer      <= '0;
            beats      <= '0;
            mism       <= 1'b0;
            rej_pulse  <= 1'b0;
            done_tag   <= '0;
            done_kind  <= '0;
            done_beats <= '0;
            done_err   <= '0;
            jobs_done  <= '0;
        end else begin
            state     <= state_nxt;
            rej_pulse <= rej;
            beats     <= beats_nxt;
            start_q   <= pop ? (3'b001 << q_mem[rd_ptr][5:4]) : 3'b000;
            if (pop) begin
                cur_kind <= q_mem[rd_ptr][5:4];
                cur_tag  <= q_mem[rd_ptr][3:0];
            end
            if (state == S_ISSUE || beat || done_seen)
                timer <= '0;
            else if (active)
                timer <= timer + 16'd1;
            if (state == S_ISSUE)
                mism <= 1'b0;
            else if (done_wrong)
                mism <= 1'b1;
            // Record is captured on entry so done_* are valid alongside done_valid.
            if (state_nxt == S_REPORT && state != S_REPORT) begin
                done_tag   <= cur_tag;
                done_kind  <= cur_kind;
                done_beats <= beats_nxt;
                done_err   <= err_nxt;
                jobs_done  <= jobs_done + 16'd1;
            end
        end
    end
endmodule
